reg_file_wb_arbiter: RTL and testbench

- Schedules the register file's single write port between two writeback requesters: the ALU/jump-link path and the memory load path.
- Load writebacks have absolute priority and are never back-pressured.
- Deferred ALU writebacks are held in a small in-order FIFO, and the block back-pressures the ALU stage when that FIFO is full.
- Sits between the writeback stage and the register file write port. It consumes the write enable and write address produced by the existing write-address control.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/reg_file_wb_arbiter.sv | 108 ++++++++++
 tb/tb_reg_file_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants for the writeback path.
// Register-file geometry and the hardwired zero register.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of deferred {addr, data} register writes.
// Supports push and pop in the same cycle; count is enq - deq.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Arbitrates the register-file write port between loads and the ALU path.
// Loads always win; displaced ALU writes queue in order and drain later.
module reg_file_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 2,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_alu_wr_valid,
    input  logic [ADDR_W-1:0] w_alu_wr_addr,
    input  logic [DATA_W-1:0] w_alu_wr_data,
    output logic              w_alu_wr_ready,
    input  logic              w_mem_wr_valid,
    input  logic [ADDR_W-1:0] w_mem_wr_addr,
    input  logic [DATA_W-1:0] w_mem_wr_data,
    output logic              w_rf_wen,
    output logic [ADDR_W-1:0] w_rf_waddr,
    output logic [DATA_W-1:0] w_rf_wdata,
    output logic [CW-1:0]     w_fifo_count,
    output logic              w_stall
);

    localparam int EW = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              issue;
    logic              alu_live;
    logic              mem_live;
    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign w_alu_wr_ready = !full;
    assign w_stall        = full;

    // Writes to r0 complete the handshake but are otherwise dropped.
    assign alu_live = w_alu_wr_valid && w_alu_wr_ready
                      && (w_alu_wr_addr != ZERO);
    assign mem_live = w_mem_wr_valid && (w_mem_wr_addr != ZERO);

    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        issue    = 1'b0;
        sel_addr = w_rf_waddr;
        sel_data = w_rf_wdata;
        priority case (1'b1)
            mem_live: begin
                issue    = 1'b1;
                push     = alu_live;
                sel_addr = w_mem_wr_addr;
                sel_data = w_mem_wr_data;
            end
            !empty: begin
                issue    = 1'b1;
                pop      = 1'b1;
                push     = alu_live;
                sel_addr = head[EW-1:DATA_W];
                sel_data = head[DATA_W-1:0];
            end
            alu_live: begin
                issue    = 1'b1;
                sel_addr = w_alu_wr_addr;
                sel_data = w_alu_wr_data;
            end
            default: ;
        endcase
    end

    wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({w_alu_wr_addr, w_alu_wr_data}),
        .dout  (head),
        .count (w_fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_rf_wen   <= 1'b0;
            w_rf_waddr <= '0;
            w_rf_wdata <= '0;
        end else begin
            w_rf_wen <= issue;
            if (issue) begin
                w_rf_waddr <= sel_addr;
                w_rf_wdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Bench for reg_file_wb_arbiter: directed vector table, reset corners,
// then random traffic against a queue-based reference model.
module tb_reg_file_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NVEC  = 15;
    localparam int NRND  = 2000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          alu_v = 1'b0;
    logic [AW-1:0] alu_a = '0;
    logic [DW-1:0] alu_d = '0;
    logic          alu_rdy;
    logic          mem_v = 1'b0;
    logic [AW-1:0] mem_a = '0;
    logic [DW-1:0] mem_d = '0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [CW-1:0] fcount;
    logic          stall;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic          rdy;
        logic          wen;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        int            cnt;
    } vec_t;

    vec_t vt [NVEC];

    reg_file_wb_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .w_alu_wr_valid (alu_v),
        .w_alu_wr_addr  (alu_a),
        .w_alu_wr_data  (alu_d),
        .w_alu_wr_ready (alu_rdy),
        .w_mem_wr_valid (mem_v),
        .w_mem_wr_addr  (mem_a),
        .w_mem_wr_data  (mem_d),
        .w_rf_wen       (rf_wen),
        .w_rf_waddr     (rf_waddr),
        .w_rf_wdata     (rf_wdata),
        .w_fifo_count   (fcount),
        .w_stall        (stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic av, input int aa, input int ad,
        input logic mv, input int ma, input int md,
        input logic rdy, input logic wen, input int wa, input int wd,
        input int cnt);
        vec_t v;
        v.av  = av;
        v.aa  = AW'(aa);
        v.ad  = DW'(ad);
        v.mv  = mv;
        v.ma  = AW'(ma);
        v.md  = DW'(md);
        v.rdy = rdy;
        v.wen = wen;
        v.wa  = AW'(wa);
        v.wd  = DW'(wd);
        v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad, input logic mv,
                         input logic [AW-1:0] ma, input logic [DW-1:0] md);
        alu_v = av;
        alu_a = aa;
        alu_d = ad;
        mem_v = mv;
        mem_a = ma;
        mem_d = md;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model state for the random phase.
    logic [AW+DW-1:0] q [$];
    logic [AW-1:0]    m_wa;
    logic [DW-1:0]    m_wd;

    initial begin
        // Reset held with requests active.
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        repeat (3) tick();
        check("rst wen", 64'(rf_wen), 64'd0);
        check("rst count", 64'(fcount), 64'd0);
        check("rst ready", 64'(alu_rdy), 64'd1);
        check("rst stall", 64'(stall), 64'd0);
        check("rst waddr", 64'(rf_waddr), 64'd0);
        check("rst wdata", 64'(rf_wdata), 64'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        reset = 1'b1;
        tick();
        check("post-rst wen", 64'(rf_wen), 64'd0);

        vt[0]  = mk(1, 3, 'h11,  0, 0, 0,      1, 1, 3, 'h11, 0);
        vt[1]  = mk(1, 6, 'hBB,  1, 5, 'hAA,   1, 1, 5, 'hAA, 1);
        vt[2]  = mk(0, 0, 0,     0, 0, 0,      1, 1, 6, 'hBB, 0);
        vt[3]  = mk(1, 1, 'hA1,  1, 10, 'h100, 1, 1, 10, 'h100, 1);
        vt[4]  = mk(1, 2, 'hA2,  1, 11, 'h101, 1, 1, 11, 'h101, 2);
        vt[5]  = mk(1, 7, 'hA7,  1, 12, 'h102, 0, 1, 12, 'h102, 2);
        vt[6]  = mk(1, 7, 'hA7,  0, 0, 0,      0, 1, 1, 'hA1, 1);
        vt[7]  = mk(1, 7, 'hA7,  0, 0, 0,      1, 1, 2, 'hA2, 1);
        vt[8]  = mk(0, 0, 0,     0, 0, 0,      1, 1, 7, 'hA7, 0);
        vt[9]  = mk(1, 0, 'hFF,  0, 0, 0,      1, 0, 7, 'hA7, 0);
        vt[10] = mk(0, 0, 0,     1, 0, 'hEE,   1, 0, 7, 'hA7, 0);
        vt[11] = mk(1, 8, 'h88,  1, 13, 'h33,  1, 1, 13, 'h33, 1);
        vt[12] = mk(1, 9, 'h99,  0, 0, 0,      1, 1, 8, 'h88, 1);
        vt[13] = mk(0, 0, 0,     0, 0, 0,      1, 1, 9, 'h99, 0);
        vt[14] = mk(0, 0, 0,     0, 0, 0,      1, 0, 9, 'h99, 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vt[i].av, vt[i].aa, vt[i].ad,
                  vt[i].mv, vt[i].ma, vt[i].md);
            #1;
            check($sformatf("v%0d ready", i), 64'(alu_rdy), 64'(vt[i].rdy));
            check($sformatf("v%0d stall", i), 64'(stall), 64'(!vt[i].rdy));
            tick();
            check($sformatf("v%0d wen", i), 64'(rf_wen), 64'(vt[i].wen));
            check($sformatf("v%0d waddr", i), 64'(rf_waddr), 64'(vt[i].wa));
            check($sformatf("v%0d wdata", i), 64'(rf_wdata), 64'(vt[i].wd));
            check($sformatf("v%0d count", i), 64'(fcount), 64'(vt[i].cnt));
        end

        // Reset mid-drain with two buffered writes.
        drive(1'b1, 5'd14, 32'hC1, 1'b1, 5'd15, 32'hD1);
        tick();
        drive(1'b1, 5'd16, 32'hC2, 1'b1, 5'd17, 32'hD2);
        tick();
        check("mid count2", 64'(fcount), 64'd2);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        reset = 1'b0;
        #1;
        check("async wen", 64'(rf_wen), 64'd0);
        check("async count", 64'(fcount), 64'd0);
        check("async waddr", 64'(rf_waddr), 64'd0);
        check("async wdata", 64'(rf_wdata), 64'd0);
        check("async ready", 64'(alu_rdy), 64'd1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stale wen %0d", i), 64'(rf_wen), 64'd0);
            check($sformatf("stale count %0d", i), 64'(fcount), 64'd0);
        end

        // Random traffic against the reference model.
        m_wa = '0;
        m_wd = '0;
        for (int i = 0; i < NRND; i++) begin
            logic          av, mv, e_rdy, e_wen, alive, mlive;
            logic [AW-1:0] aa, ma;
            logic [DW-1:0] ad, md;
            av = ($urandom_range(0, 3) != 0);
            mv = ($urandom_range(0, 1) != 0);
            aa = AW'($urandom_range(0, 31));
            ma = AW'($urandom_range(0, 31));
            ad = DW'($urandom);
            md = DW'($urandom);
            e_rdy = (q.size() < DEPTH);
            alive = av && e_rdy && (aa != 0);
            mlive = mv && (ma != 0);
            e_wen = 1'b1;
            if (mlive) begin
                {m_wa, m_wd} = {ma, md};
                if (alive) q.push_back({aa, ad});
            end else if (q.size() > 0) begin
                {m_wa, m_wd} = q.pop_front();
                if (alive) q.push_back({aa, ad});
            end else if (alive) begin
                {m_wa, m_wd} = {aa, ad};
            end else begin
                e_wen = 1'b0;
            end
            drive(av, aa, ad, mv, ma, md);
            #1;
            check($sformatf("r%0d ready", i), 64'(alu_rdy), 64'(e_rdy));
            check($sformatf("r%0d stall", i), 64'(stall), 64'(!e_rdy));
            tick();
            check($sformatf("r%0d wen", i), 64'(rf_wen), 64'(e_wen));
            check($sformatf("r%0d waddr", i), 64'(rf_waddr), 64'(m_wa));
            check($sformatf("r%0d wdata", i), 64'(rf_wdata), 64'(m_wd));
            check($sformatf("r%0d count", i), 64'(fcount), 64'(q.size()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
